// File: rtl/aes_pkg.sv
// Shared AES-128 constants, byte-level transforms and the sequencer state type.
// State bytes are column-major: byte 0 sits in [127:120], byte 4*c+r is row r of column c.
package aes_pkg;

    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Indexed directly by the round number; entries 0 and 11..15 are never used.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [BLK_W-1:0] shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_mid_round.sv
// One full AES-128 round plus the matching key-schedule step, purely combinational.
// The new round key is produced first and folded into the round output directly.
module aes_mid_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] i_st,
    input  logic [BLK_W-1:0] i_key,
    input  logic [3:0]       i_rnd,
    output logic [BLK_W-1:0] o_next_st,
    output logic [BLK_W-1:0] o_next_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    assign w_t  = sub_word(rot_word(w_w3)) ^ {RCON[i_rnd], 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_next_key = {w_n0, w_n1, w_n2, w_n3};
    assign o_next_st  = mix_columns(shift_rows(sub_bytes(i_st))) ^ o_next_key;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 front end: initial AddRoundKey on accept, then rounds 1..9 one per clock,
// handing the round-9 state and key to the last-round stage over valid/ready.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int N_MID  = 9,
    parameter int RND_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_key,
    output logic [RND_W-1:0]  out_round,
    output logic              busy
);

    seq_state_t        r_state;
    logic [DATA_W-1:0] r_st;
    logic [DATA_W-1:0] r_key;
    logic [RND_W-1:0]  r_rnd;
    logic              r_out_valid;
    logic [RND_W-1:0]  r_out_round;
    logic              r_busy;

    logic [DATA_W-1:0] w_next_st;
    logic [DATA_W-1:0] w_next_key;

    aes_mid_round u_mid_round (
        .i_st       (r_st),
        .i_key      (r_key),
        .i_rnd      (r_rnd),
        .o_next_st  (w_next_st),
        .o_next_key (w_next_key)
    );

    // Combinational from out_ready so a new block can load on the handoff edge.
    assign in_ready  = (r_state == IDLE) | ((r_state == HOLD) & out_ready);

    assign out_valid = r_out_valid;
    assign out_data  = r_st;
    assign out_key   = r_key;
    assign out_round = r_out_round;
    assign busy      = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_key       <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
            r_out_round <= '0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
            r_out_round <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_st    <= in_data ^ in_key;
                        r_key   <= in_key;
                        r_rnd   <= RND_W'(1);
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_st  <= w_next_st;
                    r_key <= w_next_key;
                    r_rnd <= r_rnd + RND_W'(1);
                    if (r_rnd == RND_W'(N_MID)) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                        r_out_round <= RND_W'(N_MID + 1);
                    end
                end
                HOLD: begin
                    // st/key/rnd stay frozen for as long as the consumer stalls.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_round <= '0;
                        if (in_valid) begin
                            r_st    <= in_data ^ in_key;
                            r_key   <= in_key;
                            r_rnd   <= RND_W'(1);
                            r_state <= RUN;
                        end else begin
                            r_rnd   <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rnd       <= '0;
                    r_out_valid <= 1'b0;
                    r_out_round <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: a byte-array AES model (S-box derived from the
// GF(2^8) inverse) predicts each block; a negedge monitor checks every handoff.
module tb_aes_round_sequencer;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         busy;

    aes_round_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_key   (out_key),
        .out_round (out_round),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [127:0] d;
        logic [127:0] k;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   rise_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    byte unsigned sbox_m [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_D9  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] C1_K9  = 128'h549932d1f08557681093ed9cbe2c974e;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic byte unsigned gmul(input byte unsigned a_in, input byte unsigned b_in);
        byte unsigned a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic byte unsigned rotl8(input byte unsigned x, input int n);
        byte unsigned y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic void build_sbox();
        byte unsigned inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic void aes9(input logic [127:0] pt, input logic [127:0] key,
                                 output logic [127:0] od, output logic [127:0] ok);
        byte unsigned s[16], k[16], t[16], tmp[4], a[4];
        byte unsigned rc;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 9; rnd++) begin
            tmp[0] = sbox_m[k[13]] ^ rc;
            tmp[1] = sbox_m[k[14]];
            tmp[2] = sbox_m[k[15]];
            tmp[3] = sbox_m[k[12]];
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ tmp[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) a[i] = s[4*c + i];
                for (int i = 0; i < 4; i++)
                    s[4*c + i] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03) ^ a[(i+2)%4] ^ a[(i+3)%4];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        od = '0; ok = '0;
        for (int i = 0; i < 16; i++) begin
            od[127-8*i -: 8] = s[i];
            ok[127-8*i -: 8] = k[i];
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic         prev_v = 1'b0;
        logic         prev_hs = 1'b0;
        logic [127:0] prev_d = '0;
        logic [127:0] prev_k = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_v) begin
                    rise_q.push_back(cyc);
                    if (exp_q.size() > 0) chk("latency", 128'(cyc - exp_q[0].acc), 128'd9);
                end
                if (out_valid && prev_v && !prev_hs) begin
                    chk("stall_data", out_data, prev_d);
                    chk("stall_key", out_key, prev_k);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 128'd1, 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_key", out_key, e.k);
                        chk("out_round", 128'(out_round), 128'd10);
                    end
                end
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
            prev_d  = out_data;
            prev_k  = out_key;
        end
    end

    // ---------------- driver helpers (phase: 1 time unit after posedge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] ed, input logic [127:0] ek, input bit rnd_ready);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back('{d: ed, k: ek, acc: cyc + 1});
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = rand128();
        in_key   = rand128();
        chk("accept", 128'(done), 128'd1);
    endtask

    task automatic send_model(input bit rnd_ready);
        logic [127:0] pt, key, ed, ek;
        pt  = rand128();
        key = rand128();
        aes9(pt, key, ed, ek);
        send(pt, key, ed, ek, rnd_ready);
    endtask

    task automatic wait_valid(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("wait_valid", 128'(seen), 128'd1);
    endtask

    task automatic drain(input int max_cyc);
        bit empty;
        empty = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < max_cyc && !empty; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) empty = 1'b1;
            tick();
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out_data"}, out_data, 128'd0);
        chk({tag, "_out_key"}, out_key, 128'd0);
        chk({tag, "_out_round"}, 128'(out_round), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] ed, ek;
        int gap;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // T1: FIPS-197 C.1 with the consumer always ready
        out_ready = 1'b1;
        send(C1_PT, C1_KEY, C1_D9, C1_K9, 1'b0);
        drain(30);
        @(negedge clk);
        chk("t1_idle_busy", 128'(busy), 128'd0);
        tick();

        // T2: 20 cycles of back-pressure in HOLD
        out_ready = 1'b0;
        send(C1_PT, C1_KEY, C1_D9, C1_K9, 1'b0);
        wait_valid(20);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 128'(out_valid), 128'd1);
            chk("t2_hold_in_ready", 128'(in_ready), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t2_after_busy", 128'(busy), 128'd0);
        chk("t2_after_valid", 128'(out_valid), 128'd0);
        chk("t2_after_round", 128'(out_round), 128'd0);
        tick();

        // T3: second block offered while the first is handed off
        out_ready = 1'b1;
        rise_q.delete();
        send_model(1'b0);
        send_model(1'b0);
        drain(40);
        chk("t3_rises", 128'(rise_q.size()), 128'd2);
        if (rise_q.size() == 2) chk("t3_spacing", 128'(rise_q[1] - rise_q[0]), 128'd10);

        // T4: flush at rnd=5 together with a fresh in_valid
        out_ready = 1'b1;
        send_model(1'b0);
        repeat (4) tick();
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = rand128();
        in_key = rand128();
        exp_q.delete();
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_in_ready", 128'(in_ready), 128'd1);
        tick();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("t4_no_valid", 128'(out_valid), 128'd0);
            chk("t4_no_load", 128'(busy), 128'd0);
            tick();
        end

        // T5: async reset mid-RUN and mid-HOLD, then a clean C.1 run
        out_ready = 1'b0;
        send(C1_PT, C1_KEY, C1_D9, C1_K9, 1'b0);
        repeat (4) tick();
        pulse_reset("t5_run");
        send(C1_PT, C1_KEY, C1_D9, C1_K9, 1'b0);
        wait_valid(20);
        repeat (3) tick();
        pulse_reset("t5_hold");
        out_ready = 1'b1;
        send(C1_PT, C1_KEY, C1_D9, C1_K9, 1'b0);
        drain(30);

        // T6: random blocks with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            send_model(1'b1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        drain(200);
        chk("t6_no_drops", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
